int_to_float_pipe: RTL and testbench

- Pipelined, parameterised integer-to-floating-point converter for the floating point module.
- Accepts signed or unsigned IN_W-bit integers and produces IEEE-754-style {sign, exponent, fraction} words with selectable rounding and an inexact flag.
- Uses valid/ready handshakes on both sides, with full backpressure.
- Sits between the integer datapath and the FP unit's operand muxes.

---
 rtl/fp_pkg.sv | 24 ++
 rtl/lzc_norm.sv | 31 +++
 rtl/int_to_float_pipe.sv | 147 ++++++++++++++
 tb/tb_int_to_float_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP helpers: rounding-mode codes, exponent bias, packed-float field widths.
// Latency: none (constants and elaboration-time functions only).
// Backpressure: not applicable.
package fp_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Leading-zero count width; a 1-bit field is kept even for degenerate widths.
    function automatic int lz_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/lzc_norm.sv
// Leading-zero count and left-normalising shift via a log2 shift tree.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
module lzc_norm
    import fp_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]            in_dat,
    output logic [W-1:0]            norm_dat,
    output logic [lz_width(W)-1:0]  lz
);

    localparam int LZW = lz_width(W);

    logic [W-1:0] stg [LZW+1];

    assign stg[0] = in_dat;

    // Largest shift first: if the top SH bits are all zero, shift them out.
    for (genvar i = 0; i < LZW; i++) begin : g_stage
        localparam int SH = 1 << (LZW - 1 - i);
        logic zero_top;
        assign zero_top        = ~|stg[i][W-1 -: SH];
        assign lz[LZW-1-i]     = zero_top;
        assign stg[i+1]        = zero_top ? (stg[i] << SH) : stg[i];
    end

    assign norm_dat = stg[LZW];

endmodule

// File: rtl/int_to_float_pipe.sv
// Integer to IEEE-style float converter: capture/negate, normalise, round and pack.
// Latency: 3 cycles, 1 result per cycle.
// Backpressure: bubble-collapsing valid/ready; out_data holds while out_ready is low.
module int_to_float_pipe
    import fp_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int SIGNED = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [IN_W-1:0]                    in_data,
    input  logic [1:0]                         in_rm,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [fp_width(EXP_W, MAN_W)-1:0]  out_data,
    output logic                               out_inexact
);

    localparam int OUT_W = fp_width(EXP_W, MAN_W);
    localparam int LZW   = lz_width(IN_W);
    localparam int SIG_W = MAN_W + 1;
    localparam int EXT_W = IN_W + SIG_W + 1;
    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(exp_bias(EXP_W) + IN_W - 1);

    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    logic            s1_sign, s1_zero;
    logic [IN_W-1:0] s1_mag;
    logic [1:0]      s1_rm;

    logic            s2_sign, s2_zero;
    logic [IN_W-1:0] s2_norm;
    logic [LZW-1:0]  s2_lz;
    logic [1:0]      s2_rm;

    assign adv3      = !v3 || out_ready;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v3;

    // S1: sign/magnitude; the most negative value negates to 2**(IN_W-1) unsigned.
    logic            in_sign;
    logic [IN_W-1:0] in_mag;

    assign in_sign = (SIGNED != 0) && in_data[IN_W-1];
    assign in_mag  = in_sign ? (~in_data + 1'b1) : in_data;

    // S2: normalise.
    logic [IN_W-1:0] norm_c;
    logic [LZW-1:0]  lz_c;

    lzc_norm #(
        .W (IN_W)
    ) u_lzc_norm (
        .in_dat   (s1_mag),
        .norm_dat (norm_c),
        .lz       (lz_c)
    );

    // S3: round and pack; zero padding below norm keeps g/st at 0 for narrow inputs.
    logic [EXT_W-1:0] ext;
    logic [SIG_W-1:0] sig;
    logic [SIG_W:0]   sig_r;
    logic             g, st, inc, carry;
    logic [MAN_W-1:0] frac;
    logic [EXP_W-1:0] exp_v;
    logic [OUT_W-1:0] s3_data;
    logic             s3_inexact;

    assign ext = {s2_norm, {(SIG_W + 1){1'b0}}};
    assign sig = ext[EXT_W-1 -: SIG_W];
    assign g   = ext[EXT_W-1-SIG_W];
    assign st  = |ext[EXT_W-2-SIG_W:0];

    always_comb begin
        inc = 1'b0;
        case (s2_rm)
            RM_RNE:  inc = g & (st | sig[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = (g | st) & ~s2_sign;
            default: inc = (g | st) & s2_sign;
        endcase
    end

    assign sig_r = {1'b0, sig} + {{SIG_W{1'b0}}, inc};
    assign carry = sig_r[SIG_W];
    // On carry-out the significand renormalises by one; its fraction bits are zero.
    assign frac  = carry ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
    assign exp_v = EXP_TOP - EXP_W'(s2_lz) + EXP_W'(carry);

    assign s3_data    = s2_zero ? '0 : {s2_sign, exp_v, frac};
    assign s3_inexact = !s2_zero && (g | st);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1) v1 <= in_valid;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign     <= 1'b0;
            s1_zero     <= 1'b0;
            s1_mag      <= '0;
            s1_rm       <= '0;
            s2_sign     <= 1'b0;
            s2_zero     <= 1'b0;
            s2_norm     <= '0;
            s2_lz       <= '0;
            s2_rm       <= '0;
            out_data    <= '0;
            out_inexact <= 1'b0;
        end else begin
            if (in_valid && adv1) begin
                s1_sign <= in_sign;
                s1_mag  <= in_mag;
                s1_rm   <= in_rm;
                s1_zero <= (in_data == '0);
            end
            if (v1 && adv2) begin
                s2_sign <= s1_sign;
                s2_zero <= s1_zero;
                s2_norm <= norm_c;
                s2_lz   <= lz_c;
                s2_rm   <= s1_rm;
            end
            if (v2 && adv3) begin
                out_data    <= s3_data;
                out_inexact <= s3_inexact;
            end
        end
    end

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Directed bench for int_to_float_pipe: signed and unsigned instances fed in lockstep.
// Scoreboard queue holds per-word expectations; monitor samples on the falling edge.
module tb_int_to_float_pipe;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [31:0] in_data;
    logic [1:0]  in_rm;
    logic        in_ready, out_valid, out_inexact;
    logic [31:0] out_data;
    logic        in_ready_u, out_valid_u, out_inexact_u;
    logic [31:0] out_data_u;

    always #5 clk = ~clk;

    int_to_float_pipe #(.IN_W(32), .EXP_W(8), .MAN_W(23), .SIGNED(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_rm(in_rm), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_inexact(out_inexact)
    );

    int_to_float_pipe #(.IN_W(32), .EXP_W(8), .MAN_W(23), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_data(in_data), .in_rm(in_rm), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_data(out_data_u), .out_inexact(out_inexact_u)
    );

    typedef struct {
        logic [31:0] es;
        logic        ei;
        bit          cu;
        logic [31:0] eu;
        logic        eui;
        bit          lat;
        int          cyc;
    } sb_t;

    sb_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   cyc     = 0;

    logic [31:0] cur_es, cur_eu;
    logic        cur_ei, cur_eui;
    bit          cur_cu, cur_lat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Independent reference: locate MSB, shift right, round on remainder vs half-ulp.
    function automatic logic [32:0] ref_cvt(input logic [31:0] x, input logic [1:0] rm, input bit sgn);
        logic        s, inx, up;
        logic [31:0] m, q, rem, half;
        logic [7:0]  ev;
        int          e, sh;
        s = sgn && x[31];
        m = s ? (32'd0 - x) : x;
        if (m == 32'd0) return 33'd0;
        e = 31;
        while (m[e] == 1'b0) e--;
        rem = 32'd0; half = 32'd0; sh = 0; up = 1'b0;
        if (e <= 23) q = m << (23 - e);
        else begin
            sh   = e - 23;
            q    = m >> sh;
            rem  = m & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
        end
        inx = (rem != 32'd0);
        case (rm)
            RM_RNE:  up = (rem > half) || (inx && rem == half && q[0]);
            RM_RTZ:  up = 1'b0;
            RM_RUP:  up = inx && !s;
            default: up = inx && s;
        endcase
        q = q + {31'd0, up};
        if (q[24]) begin q = q >> 1; e++; end
        ev = 8'(127 + e);
        return {inx, s, ev, q[22:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    logic        hold_vld = 1'b0;
    logic [31:0] hold_dat;
    logic        hold_inx;

    always @(negedge clk) begin
        sb_t  e;
        logic exp_rdy;
        if (!rst_n) begin
            hold_vld = 1'b0;
        end else begin
            exp_rdy = !(sb.size() == 3 && !out_ready);
            check("in_ready", in_ready, exp_rdy);
            check("in_ready_u", in_ready_u, exp_rdy);
            if (hold_vld) begin
                check("hold_vld", out_valid, 1);
                check("hold_dat", out_data, hold_dat);
                check("hold_inx", out_inexact, hold_inx);
            end
            hold_vld = out_valid && !out_ready;
            hold_dat = out_data;
            hold_inx = out_inexact;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("spurious_out", out_valid, 0);
                else begin
                    e = sb.pop_front();
                    n_out++;
                    check("data", out_data, e.es);
                    check("inexact", out_inexact, e.ei);
                    if (e.lat) check("latency", cyc - e.cyc, 3);
                    if (e.cu) begin
                        check("u_valid", out_valid_u, 1);
                        check("u_data", out_data_u, e.eu);
                        check("u_inexact", out_inexact_u, e.eui);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.es = cur_es; e.ei = cur_ei; e.cu = cur_cu; e.eu = cur_eu;
                e.eui = cur_eui; e.lat = cur_lat; e.cyc = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [1:0] rm,
                        input logic [31:0] es, input logic ei,
                        input bit cu, input logic [31:0] eu, input logic eui, input bit lat);
        bit took;
        int n;
        in_data = d; in_rm = rm;
        cur_es = es; cur_ei = ei; cur_cu = cu; cur_eu = eu; cur_eui = eui; cur_lat = lat;
        in_valid = 1'b1;
        took = 1'b0;
        n = 0;
        while (!took && n < 50) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!took) check("send_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [31:0] d, input logic [1:0] rm, input bit lat);
        logic [32:0] rs, ru;
        rs = ref_cvt(d, rm, 1'b1);
        ru = ref_cvt(d, rm, 1'b0);
        send(d, rm, rs[31:0], rs[32], 1'b1, ru[31:0], ru[32], lat);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", sb.size(), 0);
    endtask

    logic [31:0] t4_val [10];
    logic [1:0]  t4_rm  [10];
    logic [23:0] t4_pat;

    initial begin
        int base;
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_rm = RM_RNE; out_ready = 1'b1;
        cur_es = '0; cur_ei = 0; cur_cu = 0; cur_eu = '0; cur_eui = 0; cur_lat = 0;
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_inexact", out_inexact, 0);
        check("rst_valid_u", out_valid_u, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic values, zero, and -1.
        send(32'h0000_0001, RM_RNE, 32'h3F80_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, RM_RNE, 32'hBF80_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        send(32'h0000_0000, RM_RNE, 32'h0000_0000, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        // Rounding modes sampled per word.
        send(32'h0100_0001, RM_RNE, 32'h4B80_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        send(32'h0100_0001, RM_RUP, 32'h4B80_0001, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        send(32'h0100_0001, RM_RDN, 32'h4B80_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        send(32'hFEFF_FFFF, RM_RDN, 32'hCB80_0001, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        // Carry path and most negative value.
        send(32'h7FFF_FFFF, RM_RNE, 32'h4F00_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, RM_RTZ, 32'h4EFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        send(32'h8000_0000, RM_RNE, 32'hCF00_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // Unsigned instance on all-ones.
        send(32'hFFFF_FFFF, RM_RNE, 32'hBF80_0000, 1'b0, 1'b1, 32'h4F80_0000, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, RM_RTZ, 32'hBF80_0000, 1'b0, 1'b1, 32'h4F7F_FFFF, 1'b1, 1'b1);
        drain();

        // Back-to-back stream under a ragged out_ready pattern with a 5-cycle stall.
        t4_val = '{32'h0000_0005, 32'hFFFF_FFF0, 32'h1234_5678, 32'h8000_0001, 32'h00FF_FFFF,
                   32'h7FFF_FFC0, 32'h0300_0001, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0100_0003};
        t4_rm  = '{RM_RNE, RM_RNE, RM_RNE, RM_RDN, RM_RUP,
                   RM_RNE, RM_RUP, RM_RTZ, RM_RUP, RM_RNE};
        t4_pat = 24'b1111_0101_1011_1010_0000_1101;
        base = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) send_model(t4_val[i], t4_rm[i], 1'b0);
            end
            begin
                for (int k = 0; k < 24; k++) begin
                    out_ready = t4_pat[k];
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("t4_count", n_out - base, 10);

        // Asynchronous reset with a full pipeline.
        out_ready = 1'b0;
        send(32'h0000_0002, RM_RNE, 32'h4000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        send(32'h0000_0003, RM_RNE, 32'h4040_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        send(32'h0000_0004, RM_RNE, 32'h4080_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("full_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_vld", out_valid, 0);
        check("rst_async_dat", out_data, 0);
        check("rst_async_vld_u", out_valid_u, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_rst_vld", out_valid, 0);
        end
        @(posedge clk); #1;
        send(32'h0000_0001, RM_RNE, 32'h3F80_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
